fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
- Consumer for the read side of the team's synchronous FIFO. It pops one word at a time through the FIFO's read, data_out and empty signals, and serialises each word onto a UART-style line: 8N1 framing, LSB first.
- Sits between a producer-filled FIFO and an off-chip serial pin.
- Owns the FIFO read strobe exclusively; no other agent reads that FIFO.

Parameters:
- WIDTH, 8, data bits per frame; must match the FIFO WIDTH.
- CLKS_PER_BIT, 16, clk cycles per serial bit. Legal range is 2 or more; the counter width is clog2(CLKS_PER_BIT).

Ports:
- clk  input  1  rising-edge system clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  when low, no new frame starts; a frame in progress completes.
- fifo_empty  input  1  FIFO empty flag, combinational from the FIFO pointers.
- fifo_data  input  WIDTH  FIFO data_out, registered in the FIFO, valid the cycle after a read.
- fifo_read  output  1  one-cycle pop strobe to the FIFO.
- tx  output  1  serial line; idle level is high.
- busy  output  1  high whenever the FSM is not in IDLE.
- frame_done  output  1  one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - state = IDLE, tx = 1, fifo_read = 0, busy = 0, frame_done = 0.
  - Shift register and counters are cleared to 0.
  - A partial frame is abandoned. The line returns high with no stop-bit fix-up.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- FSM states and transitions:
  - IDLE: tx = 1. When enable = 1 and fifo_empty = 0, go to FETCH; otherwise stay in IDLE.
  - FETCH: fifo_read = 1 for exactly this one cycle; then go to LOAD.
  - LOAD: fifo_data is valid in this cycle. Capture it into the shift register at the end of LOAD; then go to START.
  - START: tx = 0 for CLKS_PER_BIT cycles; then go to DATA.
  - DATA: tx = shreg[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit. After WIDTH bits, go to STOP.
  - STOP: tx = 1 for CLKS_PER_BIT cycles. frame_done = 1 on the final cycle. Then go to IDLE.
- Framing and timing:
  - Bit counter runs 0..WIDTH-1.
  - Baud counter runs 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - Frame length from the first start-bit cycle to the last stop-bit cycle is (WIDTH+2)*CLKS_PER_BIT cycles.
- Latency:
  - fifo_empty falls in cycle N, sampled in IDLE.
  - fifo_read is high in cycle N+1.
  - The start bit begins in cycle N+3.
- Back-to-back frames: with a non-empty FIFO, successive frames are separated by exactly 3 idle-high cycles (IDLE, FETCH, LOAD).
- fifo_read is never asserted while fifo_empty = 1 in the sampling IDLE cycle, so this block never causes FIFO underflow.
- fifo_read is asserted at most once per frame.
- enable is sampled only in IDLE. Deasserting it mid-frame has no effect on the current frame.
- busy = 1 in FETCH through STOP inclusive.
- FIFO writes concurrent with any state are irrelevant to this block.

Decomposition:
- Package fifo_uart_tx_pkg:
  - state enumeration: IDLE, FETCH, LOAD, START, DATA, STOP, 3-bit encoding;
  - line level constants: LINE_IDLE = 1, START_BIT = 0, STOP_BIT = 1.
- One sub-module, bit_timer:
  - free-running modulo-CLKS_PER_BIT counter;
  - clear input, bit_tick output pulsing on count CLKS_PER_BIT-1;
  - same clk and reset.
- Top-level FSM, shift register and bit counter stay in fifo_uart_tx.

Test Plan:
- Reset mid-frame:
  - CLKS_PER_BIT=4. Assert reset during DATA bit 3.
  - tx = 1, busy = 0, fifo_read = 0 within the same cycle, with no clock edge needed.
  - After release, no frame starts until fifo_empty = 0.
- Single word:
  - CLKS_PER_BIT=4. FIFO holds 0xA5, enable = 1.
  - fifo_read pulses once.
  - tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles, 40 cycles total.
  - frame_done pulses on cycle 40 of the frame; busy then falls.
- Back-to-back:
  - FIFO holds 0x00 then 0xFF.
  - Two frames, exactly 3 high cycles between the stop of frame 1 and the start of frame 2.
  - Exactly 2 fifo_read pulses; fifo_empty ends at 1.
- Empty FIFO:
  - fifo_empty held at 1 for 100 cycles, enable = 1.
  - fifo_read never asserts, tx stays 1, busy stays 0.
- Enable gating:
  - Drop enable during frame 1 with 3 words queued.
  - Frame 1 completes in full; no further fifo_read while enable = 0.
  - Re-assert enable: frame 2 starts 3 cycles later.
- Full FIFO drain:
  - FIFO filled to its full capacity with 7 words (0x01..0x07).
  - 7 frames emitted in order, 7 fifo_read pulses, 7 frame_done pulses, fifo_empty = 1 at the end.

Source files
------------

// File: rtl/fifo_uart_tx_pkg.sv
// Shared state encoding and serial line levels for the FIFO-fed UART transmitter.
package fifo_uart_tx_pkg;

   typedef logic [2:0] state_t;

   localparam state_t IDLE  = 3'd0;
   localparam state_t FETCH = 3'd1;
   localparam state_t LOAD  = 3'd2;
   localparam state_t START = 3'd3;
   localparam state_t DATA  = 3'd4;
   localparam state_t STOP  = 3'd5;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_bit_timer.sv
// Modulo-CLKS_PER_BIT baud counter; o_bit_tick marks the last cycle of each serial bit.
module bit_timer #(
   parameter int CLKS_PER_BIT = 16,
   parameter int CW           = $clog2(CLKS_PER_BIT)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_clear,
   output logic          o_bit_tick,
   output logic [CW-1:0] o_count
);

   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] r_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_clear || (r_count == CNT_LAST)) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_bit_tick = (r_count == CNT_LAST);
   assign o_count    = r_count;

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from a synchronous FIFO and sends each as an 8N1 LSB-first serial frame.
// Outputs are registered from the next-state decode, so each lands in the cycle of its state.
module fifo_uart_tx
   import fifo_uart_tx_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_data,
   output logic             fifo_read,
   output logic             tx,
   output logic             busy,
   output logic             frame_done
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_PENULT = CW'(CLKS_PER_BIT - 2);
   localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH - 1);

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_shreg;
   logic [WIDTH-1:0] w_shifted;
   logic [BW-1:0]    r_bit_idx;
   logic             r_tx;
   logic             r_fifo_read;
   logic             r_busy;
   logic             r_frame_done;
   logic             w_tick;
   logic             w_clear;
   logic [CW-1:0]    w_count;

   // Hold the baud counter at zero until the start bit so every bit gets a full period.
   assign w_clear   = (r_state == IDLE) || (r_state == FETCH) || (r_state == LOAD);
   assign w_shifted = r_shreg >> 1;

   bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .CW           (CW)
   ) u_bit_timer (
      .clk        (clk),
      .reset      (reset),
      .i_clear    (w_clear),
      .o_bit_tick (w_tick),
      .o_count    (w_count)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (enable && !fifo_empty) w_next = FETCH;
         FETCH:   w_next = LOAD;
         LOAD:    w_next = START;
         START:   if (w_tick) w_next = DATA;
         DATA:    if (w_tick && (r_bit_idx == BIT_LAST)) w_next = STOP;
         STOP:    if (w_tick) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_shreg      <= '0;
         r_bit_idx    <= '0;
         r_tx         <= LINE_IDLE;
         r_fifo_read  <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_fifo_read  <= (w_next == FETCH);
         r_busy       <= (w_next != IDLE);
         r_frame_done <= (r_state == STOP) && (w_count == CNT_PENULT);
         case (r_state)
            LOAD: begin
               r_shreg   <= fifo_data;
               r_bit_idx <= '0;
               r_tx      <= START_BIT;
            end
            START: begin
               if (w_tick) r_tx <= r_shreg[0];
            end
            DATA: begin
               if (w_tick) begin
                  r_shreg   <= w_shifted;
                  r_bit_idx <= r_bit_idx + 1'b1;
                  r_tx      <= (r_bit_idx == BIT_LAST) ? STOP_BIT : w_shifted[0];
               end
            end
            default: begin
               r_tx <= LINE_IDLE;
            end
         endcase
      end
   end

   assign tx         = r_tx;
   assign fifo_read  = r_fifo_read;
   assign busy       = r_busy;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed and randomized checks of fifo_uart_tx against a per-cycle line model built from frame rules.
module tb_fifo_uart_tx;

   localparam int CPB   = 4;
   localparam int W     = 8;
   localparam int DEPTH = 7;

   logic         clk = 1'b0;
   logic         reset;
   logic         enable;
   logic         fifo_empty;
   logic [W-1:0] fifo_data;
   logic         fifo_read;
   logic         tx;
   logic         busy;
   logic         frame_done;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit logging  = 1'b0;

   logic [W-1:0] fq[$];
   logic [W-1:0] words[$];
   logic tx_q[$], rd_q[$], bz_q[$], fd_q[$];
   logic e_tx[$], e_rd[$], e_bz[$], e_fd[$];

   fifo_uart_tx #(
      .WIDTH        (W),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_read  (fifo_read),
      .tx         (tx),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      cyc++;
      if (logging) begin
         tx_q.push_back(tx);
         rd_q.push_back(fifo_read);
         bz_q.push_back(busy);
         fd_q.push_back(frame_done);
      end
   end

   task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
      end
   endtask

   // FIFO model: registered data_out valid the cycle after a pop, empty follows the occupancy.
   task automatic tick();
      @(negedge clk);
      if (fifo_read === 1'b1) begin
         chk("no_underflow", cyc, 32'(fq.size() != 0), 32'd1);
         if (fq.size() != 0) fifo_data = fq.pop_front();
      end
      fifo_empty = (fq.size() == 0);
   endtask

   task automatic start_log();
      tx_q.delete(); rd_q.delete(); bz_q.delete(); fd_q.delete();
      e_tx.delete(); e_rd.delete(); e_bz.delete(); e_fd.delete();
      logging = 1'b1;
   endtask

   task automatic model_cycle(input logic t, input logic r, input logic b, input logic f);
      e_tx.push_back(t); e_rd.push_back(r); e_bz.push_back(b); e_fd.push_back(f);
   endtask

   task automatic model_frame(input logic [W-1:0] w);
      logic lvl;
      model_cycle(1'b1, 1'b1, 1'b1, 1'b0);
      model_cycle(1'b1, 1'b0, 1'b1, 1'b0);
      for (int b = 0; b < W + 2; b++) begin
         if (b == 0) lvl = 1'b0;
         else if (b == W + 1) lvl = 1'b1;
         else lvl = w[b-1];
         for (int c = 0; c < CPB; c++)
            model_cycle(lvl, 1'b0, 1'b1, (b == W + 1) && (c == CPB - 1));
      end
   endtask

   task automatic model_pad(input int n);
      while (e_tx.size() < n) model_cycle(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   // Queue every word in 'words' at once and expect back-to-back frames separated by one IDLE.
   task automatic send_words();
      for (int i = 0; i < words.size(); i++) begin
         fq.push_back(words[i]);
         if (i > 0) model_cycle(1'b1, 1'b0, 1'b0, 1'b0);
         model_frame(words[i]);
      end
      fifo_empty = (fq.size() == 0);
   endtask

   task automatic run_log(input int n);
      repeat (n) tick();
      logging = 1'b0;
   endtask

   task automatic compare_logs(input string tag);
      int nr_obs = 0, nr_exp = 0, nf_obs = 0, nf_exp = 0;
      chk({tag, "_len"}, 0, tx_q.size(), e_tx.size());
      for (int i = 0; i < e_tx.size() && i < tx_q.size(); i++) begin
         chk({tag, "_tx"},   i, 32'(tx_q[i]), 32'(e_tx[i]));
         chk({tag, "_read"}, i, 32'(rd_q[i]), 32'(e_rd[i]));
         chk({tag, "_busy"}, i, 32'(bz_q[i]), 32'(e_bz[i]));
         chk({tag, "_done"}, i, 32'(fd_q[i]), 32'(e_fd[i]));
         if (rd_q[i] === 1'b1) nr_obs++;
         if (e_rd[i]) nr_exp++;
         if (fd_q[i] === 1'b1) nf_obs++;
         if (e_fd[i]) nf_exp++;
      end
      chk({tag, "_nreads"}, 0, nr_obs, nr_exp);
      chk({tag, "_nframes"}, 0, nf_obs, nf_exp);
   endtask

   initial begin
      int n;
      reset      = 1'b1;
      enable     = 1'b0;
      fifo_empty = 1'b1;
      fifo_data  = '0;
      #1;
      chk("reset_tx",   0, 32'(tx),         32'd1);
      chk("reset_busy", 0, 32'(busy),       32'd0);
      chk("reset_read", 0, 32'(fifo_read),  32'd0);
      chk("reset_done", 0, 32'(frame_done), 32'd0);
      repeat (3) tick();
      reset  = 1'b0;
      enable = 1'b1;
      repeat (2) tick();

      // Empty FIFO: nothing may happen for 100 cycles.
      start_log();
      model_pad(100);
      run_log(100);
      compare_logs("empty");

      // Single word 0xA5.
      tick(); start_log();
      words.delete(); words.push_back(8'hA5);
      send_words();
      model_pad(52);
      run_log(52);
      compare_logs("single");

      // Back-to-back 0x00, 0xFF.
      tick(); start_log();
      words.delete(); words.push_back(8'h00); words.push_back(8'hFF);
      send_words();
      model_pad(2 * 43 + 8);
      run_log(2 * 43 + 8);
      compare_logs("b2b");
      chk("b2b_empty_end", 0, 32'(fifo_empty), 32'd1);

      // Full FIFO drain 0x01..0x07.
      tick(); start_log();
      words.delete();
      for (int i = 1; i <= DEPTH; i++) words.push_back(W'(i));
      send_words();
      model_pad(DEPTH * 43 + 8);
      run_log(DEPTH * 43 + 8);
      compare_logs("drain");
      chk("drain_empty_end", 0, 32'(fifo_empty), 32'd1);

      // Random bursts.
      for (int r = 0; r < 4; r++) begin
         tick(); start_log();
         words.delete();
         n = int'($urandom_range(1, 3));
         for (int i = 0; i < n; i++) words.push_back(W'($urandom));
         send_words();
         model_pad(n * 43 + 8);
         run_log(n * 43 + 8);
         compare_logs("random");
      end

      // Enable gating: drop enable during frame 1 of 3 queued words.
      tick(); start_log();
      words.delete();
      for (int i = 0; i < 3; i++) words.push_back(W'($urandom));
      fq.push_back(words[0]); fq.push_back(words[1]); fq.push_back(words[2]);
      fifo_empty = 1'b0;
      model_frame(words[0]);
      model_pad(80);
      repeat (10) tick();
      enable = 1'b0;
      run_log(70);
      compare_logs("gated");
      tick(); start_log();
      enable = 1'b1;
      model_frame(words[1]);
      model_cycle(1'b1, 1'b0, 1'b0, 1'b0);
      model_frame(words[2]);
      model_pad(2 * 43 + 8);
      run_log(2 * 43 + 8);
      compare_logs("regated");
      chk("regated_empty_end", 0, 32'(fifo_empty), 32'd1);

      // Asynchronous reset during DATA bit 3 of a 0x00 frame.
      tick();
      fq.push_back(8'h00);
      fifo_empty = 1'b0;
      repeat (2 + 4 * CPB + 1) tick();
      chk("prereset_tx",   0, 32'(tx),   32'd0);
      chk("prereset_busy", 0, 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      chk("midreset_tx",   0, 32'(tx),         32'd1);
      chk("midreset_busy", 0, 32'(busy),       32'd0);
      chk("midreset_read", 0, 32'(fifo_read),  32'd0);
      chk("midreset_done", 0, 32'(frame_done), 32'd0);
      fq.delete();
      fifo_empty = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      tick(); start_log();
      model_pad(30);
      run_log(30);
      compare_logs("postreset_idle");
      tick(); start_log();
      words.delete(); words.push_back(W'($urandom));
      send_words();
      model_pad(52);
      run_log(52);
      compare_logs("postreset_frame");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
